// File: rtl/counter_ctrl_seq.sv
// Control sequencer for the display counter: pushbutton conditioning, the
// IDLE/RUN/PAUSE/DONE machine, prescaled increment ticks and the pad enable pattern.
module counter_ctrl_seq #(
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               PRESCALE        = 1000,
    parameter int               CNT_W           = 14,
    parameter int               MAX_COUNT       = 9999,
    parameter bit               AUTO_STOP       = 1'b1,
    parameter int               OEB_W           = 17,
    parameter logic [OEB_W-1:0] IN_MASK         = 17'h7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_clr,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic [1:0]       state_o,
    output logic [OEB_W-1:0] out_en
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLR   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_d_r;
    logic [2:0]      event_r;
    logic [DB_W-1:0] db_cnt_r [3];

    logic            start_ev_s;
    logic            stop_ev_s;
    logic            clr_ev_s;
    logic            at_max_s;
    logic            terminal_s;

    state_t          state_r;
    logic [PS_W-1:0] ps_r;

    assign raw_s   = {btn_clr, btn_stop, btn_start};
    assign state_o = state_r;

    // Synchronise, debounce and edge-detect the three pushbuttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            deb_r   <= 3'b000;
            deb_d_r <= 3'b000;
            event_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            // Only presses generate events; releases merely re-arm the detector
            event_r <= deb_r & ~deb_d_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= {DB_W{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    // Resolve same-cycle button events (clr > stop > start) and tick conditions
    always_comb begin
        clr_ev_s   = event_r[BTN_CLR];
        stop_ev_s  = event_r[BTN_STOP] & ~event_r[BTN_CLR];
        start_ev_s = event_r[BTN_START] & ~event_r[BTN_STOP] & ~event_r[BTN_CLR];
        at_max_s   = (cnt_val >= MAX_VAL);
        terminal_s = (ps_r == PS_LAST);
    end

    // Sequencer state, prescaler and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            ps_r    <= {PS_W{1'b0}};
            cnt_inc <= 1'b0;
            cnt_clr <= 1'b0;
            out_en  <= {OEB_W{1'b1}};
        end else begin
            out_en  <= IN_MASK;
            cnt_inc <= 1'b0;
            cnt_clr <= 1'b0;
            if (clr_ev_s) begin
                state_r <= S_IDLE;
                ps_r    <= {PS_W{1'b0}};
                cnt_clr <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        ps_r <= {PS_W{1'b0}};
                        if (start_ev_s) begin
                            state_r <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // A stop freezes the prescaler so resume keeps the tick phase
                        if (stop_ev_s) begin
                            state_r <= S_PAUSE;
                        end else if (terminal_s) begin
                            ps_r <= {PS_W{1'b0}};
                            if (!at_max_s) begin
                                cnt_inc <= 1'b1;
                            end else if (AUTO_STOP) begin
                                state_r <= S_DONE;
                            end else begin
                                cnt_clr <= 1'b1;
                            end
                        end else begin
                            ps_r <= ps_r + PS_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (start_ev_s) begin
                            state_r <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        ps_r <= {PS_W{1'b0}};
                    end
                    default: begin
                        state_r <= S_IDLE;
                        ps_r    <= {PS_W{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule
